// File: rtl/marker_gen_param_if.sv
// Control/marker bundle for marker_gen_param; MARKER_GEN_PARAM_CHK_EN adds the loopback-check signals.
interface marker_gen_param_if #(
    parameter int unsigned RATE_W = 2,
    parameter int unsigned MW     = 8
);
    logic              enable;
    logic [RATE_W-1:0] local_rate_lg;
    logic [RATE_W-1:0] remote_rate_lg;
    logic [MW-1:0]     user_marker;
    logic              marker_vld;
    logic              cfg_err;
`ifdef MARKER_GEN_PARAM_CHK_EN
    logic [MW-1:0]     rx_marker;
    logic              rx_vld;
    logic              chk_err;

    modport master (
        output enable, local_rate_lg, remote_rate_lg, rx_marker, rx_vld,
        input  user_marker, marker_vld, cfg_err, chk_err
    );
    modport slave (
        input  enable, local_rate_lg, remote_rate_lg, rx_marker, rx_vld,
        output user_marker, marker_vld, cfg_err, chk_err
    );
`else
    modport master (
        output enable, local_rate_lg, remote_rate_lg,
        input  user_marker, marker_vld, cfg_err
    );
    modport slave (
        input  enable, local_rate_lg, remote_rate_lg,
        output user_marker, marker_vld, cfg_err
    );
`endif
endinterface

// File: rtl/marker_gen_param.sv
// Parametrised user_marker generator for rate-converted links with restart and config checking.
// Define MARKER_GEN_PARAM_CHK_EN to build the sticky loopback marker checker.
module marker_gen_param #(
    parameter int unsigned MAX_LG  = 3,
    parameter int unsigned RATE_W  = 2,
    parameter int unsigned MW      = 2**MAX_LG,
    parameter int unsigned CHK_DLY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    marker_gen_param_if.slave mk_io
);
    localparam int unsigned SumW = 2 * MAX_LG + 2;
    localparam int unsigned PW   = MAX_LG + 1;
    localparam logic [RATE_W-1:0] MaxCode = RATE_W'(MAX_LG);

    typedef enum logic [1:0] {StIdle, StSettle, StRun, StErr} state_e;

    state_e            state_q;
    logic [RATE_W-1:0] loc_q, rem_q;
    logic [MAX_LG-1:0] phase_q;
    logic [MW-1:0]     marker_q;
    logic              vld_q;
    logic              cfg_err_q;

    logic              cfg_illegal;
    logic [RATE_W-1:0] lg_p;
    logic [PW-1:0]     p_mask;
    logic [MAX_LG-1:0] phase_nxt;
    logic [SumW-1:0]   r_mask;
    logic [SumW-1:0]   sum;
    logic [MW-1:0]     marker_calc;

    assign cfg_illegal = (mk_io.local_rate_lg > MaxCode) || (mk_io.remote_rate_lg > MaxCode);

    // Phase wraps at P = R/W when the remote side is slower, otherwise stays at 0.
    always_comb begin
        lg_p = '0;
        if (mk_io.remote_rate_lg > mk_io.local_rate_lg) begin
            lg_p = mk_io.remote_rate_lg - mk_io.local_rate_lg;
        end
        p_mask    = (PW'(1) << lg_p) - PW'(1);
        phase_nxt = MAX_LG'((PW'(phase_q) + PW'(1)) & p_mask);
    end

    // Word i of this beat is the last word of a remote beat when (phase*W + i + 1) mod R == 0.
    always_comb begin
        marker_calc = '0;
        sum         = '0;
        r_mask      = (SumW'(1) << mk_io.remote_rate_lg) - SumW'(1);
        for (int i = 0; i < int'(MW); i++) begin
            sum = (SumW'(phase_q) << mk_io.local_rate_lg) + SumW'(i) + SumW'(1);
            if ((SumW'(i) < (SumW'(1) << mk_io.local_rate_lg)) && ((sum & r_mask) == '0)) begin
                marker_calc[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            loc_q     <= '0;
            rem_q     <= '0;
            phase_q   <= '0;
            marker_q  <= '0;
            vld_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_illegal;
            marker_q  <= '0;
            vld_q     <= 1'b0;
            if (!mk_io.enable) begin
                state_q <= StIdle;
                phase_q <= '0;
            end else if (cfg_illegal) begin
                state_q <= StErr;
                phase_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle, StErr: begin
                        state_q <= StSettle;
                        phase_q <= '0;
                    end
                    StSettle: begin
                        loc_q    <= mk_io.local_rate_lg;
                        rem_q    <= mk_io.remote_rate_lg;
                        marker_q <= marker_calc;
                        vld_q    <= 1'b1;
                        phase_q  <= phase_nxt;
                        state_q  <= StRun;
                    end
                    StRun: begin
                        if ((mk_io.local_rate_lg != loc_q) || (mk_io.remote_rate_lg != rem_q)) begin
                            state_q <= StSettle;
                            phase_q <= '0;
                        end else begin
                            marker_q <= marker_calc;
                            vld_q    <= 1'b1;
                            phase_q  <= phase_nxt;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        phase_q <= '0;
                    end
                endcase
            end
        end
    end

    assign mk_io.user_marker = marker_q;
    assign mk_io.marker_vld  = vld_q;
    assign mk_io.cfg_err     = cfg_err_q;

`ifdef MARKER_GEN_PARAM_CHK_EN
    logic [CHK_DLY-1:0][MW-1:0] dly_mk_q;
    logic [CHK_DLY-1:0]         dly_vld_q;
    logic                       chk_err_q;

    // Delay line models the loopback path so the far end can be compared word for word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_mk_q  <= '0;
            dly_vld_q <= '0;
            chk_err_q <= 1'b0;
        end else begin
            dly_mk_q[0]  <= marker_q;
            dly_vld_q[0] <= vld_q;
            for (int k = 1; k < int'(CHK_DLY); k++) begin
                dly_mk_q[k]  <= dly_mk_q[k-1];
                dly_vld_q[k] <= dly_vld_q[k-1];
            end
            if (state_q == StIdle) begin
                chk_err_q <= 1'b0;
            end else if (mk_io.rx_vld && dly_vld_q[CHK_DLY-1] &&
                         (mk_io.rx_marker != dly_mk_q[CHK_DLY-1])) begin
                chk_err_q <= 1'b1;
            end
        end
    end

    assign mk_io.chk_err = chk_err_q;
`endif
endmodule

// File: tb/tb_marker_gen_param.sv
// Scoreboard bench for marker_gen_param: driver feeds a behavioural model, monitor checks each cycle.
module tb_marker_gen_param;
    localparam int unsigned MAX_LG  = 3;
    localparam int unsigned RATE_W  = 3;
    localparam int unsigned MW      = 8;
    localparam int unsigned CHK_DLY = 2;

    typedef struct {
        logic [MW-1:0] mk;
        logic          vld;
        logic          cfg;
        logic          chk;
        int unsigned   tgt;
    } exp_t;

    typedef enum {MIdle, MSettle, MRun, MErr} mmode_e;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    exp_t        sb_q[$];
    exp_t        m_hist[$];
    mmode_e      m_mode;
    int unsigned m_idx, m_sl, m_sr;
    logic        m_chk;

    marker_gen_param_if #(.RATE_W(RATE_W), .MW(MW)) mk_if ();

    marker_gen_param #(
        .MAX_LG (MAX_LG),
        .RATE_W (RATE_W),
        .CHK_DLY(CHK_DLY)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mk_io(mk_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, req);
        end
    endtask

    // Reference marker: word i of beat idx closes a remote beat when (idx*W + i + 1) % R == 0.
    function automatic logic [MW-1:0] pat(input int unsigned l, input int unsigned r,
                                          input int unsigned idx);
        logic [MW-1:0] v  = '0;
        int unsigned   w  = 1 << l;
        int unsigned   rr = 1 << r;
        for (int unsigned i = 0; i < w; i++) begin
            if (((idx * w + i + 1) % rr) == 0) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        exp_t z;
        z.mk = '0; z.vld = 1'b0; z.cfg = 1'b0; z.chk = 1'b0; z.tgt = 0;
        m_mode = MIdle; m_idx = 0; m_sl = 0; m_sr = 0; m_chk = 1'b0;
        m_hist.delete();
        for (int k = 0; k <= int'(CHK_DLY); k++) m_hist.push_back(z);
    endtask

    task automatic model_step(input logic en, input int unsigned l, input int unsigned r,
                              input logic rxv, input logic [MW-1:0] rxm);
        exp_t e;
        bit   legal;
        legal = (l <= MAX_LG) && (r <= MAX_LG);
        e.mk = '0; e.vld = 1'b0; e.cfg = !legal; e.tgt = cyc + 1;
        // Loopback compare sees the marker presented CHK_DLY cycles earlier.
        if (m_mode == MIdle) m_chk = 1'b0;
        else if (rxv && m_hist[0].vld && (rxm != m_hist[0].mk)) m_chk = 1'b1;
        if (!en) begin
            m_mode = MIdle;
        end else if (!legal) begin
            m_mode = MErr;
        end else begin
            case (m_mode)
                MIdle, MErr: m_mode = MSettle;
                MSettle: begin
                    m_sl = l; m_sr = r; m_idx = 0;
                    e.mk = pat(l, r, m_idx); e.vld = 1'b1; m_idx++;
                    m_mode = MRun;
                end
                default: begin
                    if (l != m_sl || r != m_sr) m_mode = MSettle;
                    else begin
                        e.mk = pat(l, r, m_idx); e.vld = 1'b1; m_idx++;
                    end
                end
            endcase
        end
        e.chk = m_chk;
        m_hist.push_back(e);
        if (m_hist.size() > CHK_DLY + 1) void'(m_hist.pop_front());
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic en, input int unsigned l, input int unsigned r,
                         input logic flip);
        logic [MW-1:0] rxm;
        logic          rxv;
        @(posedge clk);
        #1;
        rxm = m_hist[0].mk ^ {{(MW-1){1'b0}}, flip};
        rxv = flip | ($urandom_range(0, 3) != 0);
        mk_if.enable         = en;
        mk_if.local_rate_lg  = RATE_W'(l);
        mk_if.remote_rate_lg = RATE_W'(r);
`ifdef MARKER_GEN_PARAM_CHK_EN
        mk_if.rx_marker = rxm;
        mk_if.rx_vld    = rxv;
`endif
        model_step(en, l, r, rxv, rxm);
    endtask

    task automatic run(input logic en, input int unsigned l, input int unsigned r,
                       input int unsigned n);
        for (int unsigned k = 0; k < n; k++) drive(en, l, r, 1'b0);
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, "_marker"}, mk_if.user_marker, '0);
        cmp({nm, "_vld"}, MW'(mk_if.marker_vld), '0);
        cmp({nm, "_cfg_err"}, MW'(mk_if.cfg_err), '0);
`ifdef MARKER_GEN_PARAM_CHK_EN
        cmp({nm, "_chk_err"}, MW'(mk_if.chk_err), '0);
`endif
    endtask

    // Monitor: pop the entry scheduled for this cycle and compare every output.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].tgt < cyc) begin
            n_fail++;
            $display("FAIL stale_entry @cyc %0d: got tgt %0d, want %0d", cyc, sb_q[0].tgt, cyc);
            void'(sb_q.pop_front());
        end else if (sb_q.size() > 0 && sb_q[0].tgt == cyc) begin
            e = sb_q.pop_front();
            cmp("user_marker", mk_if.user_marker, e.mk);
            cmp("marker_vld", MW'(mk_if.marker_vld), MW'(e.vld));
            cmp("cfg_err", MW'(mk_if.cfg_err), MW'(e.cfg));
`ifdef MARKER_GEN_PARAM_CHK_EN
            cmp("chk_err", MW'(mk_if.chk_err), MW'(e.chk));
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog @cyc %0d: got no finish, want finish", cyc);
        $fatal(1);
    end

    initial begin
        mk_if.enable = 1'b0; mk_if.local_rate_lg = '0; mk_if.remote_rate_lg = '0;
`ifdef MARKER_GEN_PARAM_CHK_EN
        mk_if.rx_marker = '0; mk_if.rx_vld = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        run(1'b1, 2, 2, 6);          // Quarter/Quarter: 08 from cycle 2
        run(1'b1, 0, 3, 20);         // Full/Eighth: one pulse per 8
        run(1'b1, 1, 2, 8);          // Half/Quarter: 00,10
        run(1'b1, 3, 1, 6);          // AA
        run(1'b1, 3, 0, 6);          // FF
        run(1'b1, 0, 2, 5);          // reach phase 2, then change remote
        run(1'b1, 0, 1, 8);
        run(1'b1, 1, 5, 4);          // illegal remote code
        run(1'b1, 1, 1, 6);
        run(1'b0, 7, 0, 3);          // cfg_err regardless of enable
        run(1'b1, 2, 1, 6);
        drive(1'b1, 2, 1, 1'b1);     // corrupt loopback once
        run(1'b1, 2, 1, 4);
        run(1'b0, 2, 1, 3);
        run(1'b1, 2, 3, 10);

        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        sb_q.delete();
        model_reset();
        mk_if.enable = 1'b0; mk_if.local_rate_lg = '0; mk_if.remote_rate_lg = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 70; s++) begin
            logic        en;
            int unsigned l, r, len;
            en  = ($urandom_range(0, 9) != 0);
            l   = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            r   = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            len = $urandom_range(1, 14);
            for (int unsigned k = 0; k < len; k++) drive(en, l, r, ($urandom_range(0, 24) == 0));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain @cyc %0d: got %0d pending, want 0", cyc, sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/marker_gen_param.md
Name: marker_gen_param

Overview:
- Parametrised successor marker generator for AIB/LPIF-style rate-converted links.
- Produces the per-word user_marker pattern for any local/remote word-rate pair up to 2^MAX_LG words per beat, not only Full/Half/Quarter.
- Adds:
  - enable/restart control
  - phase restart on configuration change
  - illegal-config detection
  - an optional loopback marker checker
- Sits in the DV/user-side stimulus path ahead of the AIB adapter TX data mux.

Parameters:
- MAX_LG, 3, log2 of the maximum words per beat (3 → up to 8 words, i.e. 1/2/4/8 rates).
- RATE_W, 2, width of the rate code ports; must satisfy 2^RATE_W > MAX_LG.
- MW, 2**MAX_LG, marker width (derived; not to be overridden).
- CHK_DLY, 2, loopback delay in cycles used by the optional checker (1..15).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run request; low forces the IDLE state.
- local_rate_lg  input  RATE_W  log2 of local words per beat (0=Full, 1=Half, 2=Quarter, 3=Eighth).
- remote_rate_lg  input  RATE_W  log2 of remote words per beat.
- user_marker  output  MW  marker bits; bits at index ≥ 2^local_rate_lg are always 0.
- marker_vld  output  1  high when user_marker reflects a legal running configuration.
- cfg_err  output  1  high while either rate code exceeds MAX_LG.
- rx_marker  input  MW  (MARKER_GEN_PARAM_CHK_EN only) looped-back marker.
- rx_vld  input  1  (MARKER_GEN_PARAM_CHK_EN only) rx_marker qualifier.
- chk_err  output  1  (MARKER_GEN_PARAM_CHK_EN only) sticky mismatch flag.

Behaviour:
- Reset: user_marker=0, marker_vld=0, cfg_err=0, chk_err=0, phase=0, state=IDLE, config shadow registers=0.
- Definitions:
  - W = 2^local_rate_lg.
  - R = 2^remote_rate_lg.
  - P = R/W when R>W, else 1.
- phase counter:
  - MAX_LG bits wide.
  - Counts 0..P-1 and wraps to 0.
  - Held at 0 when P=1.
- Marker rule (registered): bit i (i<W) = 1 iff ((phase*W + i + 1) mod R) == 0; all other bits = 0.
  - Full/Full → 1 every cycle.
  - Full/Quarter → 0,0,0,1 repeating.
  - Half/Quarter → 00,10 repeating.
  - Quarter/Half → 1010 every cycle.
  - Quarter/Full → 1111 every cycle.
  - Quarter/Quarter → 1000 every cycle.
- State machine IDLE / SETTLE / RUN / ERR:
  - IDLE: outputs 0, phase 0. enable=1 and config legal → SETTLE. enable=1 and config illegal → ERR.
  - SETTLE:
    - Lasts exactly one cycle.
    - Captures both rate codes into shadow registers.
    - phase=0, user_marker=0.
    - Goes to RUN.
  - RUN:
    - Each cycle registers the marker for the current phase, then advances phase.
    - marker_vld=1.
    - First marker appears 2 cycles after enable rises (SETTLE plus the register).
  - Live rate ≠ shadow while in RUN (either code): go to SETTLE the next cycle, so the pattern restarts at phase 0. user_marker and marker_vld are 0 during that cycle.
  - Illegal code (> MAX_LG) in any state with enable=1: go to ERR. In ERR, cfg_err=1, user_marker=0, marker_vld=0. When the config becomes legal, go to SETTLE.
  - enable=0 in any state: go to IDLE the next cycle and clear phase. enable takes priority over config change.
- cfg_err is a registered comparison of both codes against MAX_LG. It is independent of enable.
- Reset asserted mid-run: all outputs clear asynchronously. After release, operation restarts from IDLE.

Optional Feature:
- Macro: MARKER_GEN_PARAM_CHK_EN.
- Defined:
  - The rx_marker, rx_vld and chk_err ports exist.
  - user_marker/marker_vld are delayed CHK_DLY cycles through a shift register to form the expected marker.
  - When rx_vld=1 and the expected marker_vld=1, rx_marker ≠ expected sets chk_err.
  - chk_err is sticky. It is cleared only by reset or by a cycle in IDLE.
- Undefined: the ports are absent and no checker logic is built.

Test Plan:
- Reset/enable:
  - Stimulus: rst_n=0; then rst_n=1 with enable=1, local=2, remote=2.
  - Required: user_marker=0 during reset; 4'b1000 (zero-extended to 8'h08) from cycle 2 onward; marker_vld=1 from cycle 2.
- Slow remote:
  - Stimulus: local=0, remote=3.
  - Required: user_marker bit0 = 0,0,0,0,0,0,0,1 repeating with period 8.
  - Stimulus: local=1, remote=2.
  - Required: user_marker = 00, 10, 00, 10.
- Fast remote:
  - Stimulus: local=3, remote=1.
  - Required: user_marker = 8'hAA every cycle.
  - Stimulus: local=3, remote=0.
  - Required: user_marker = 8'hFF every cycle.
- Config change mid-run:
  - Stimulus: with local=0, remote=2, switch remote to 1 at phase=2.
  - Required: one cycle of marker_vld=0 and user_marker=0; then the pattern restarts 0,1,0,1 from phase 0.
- Illegal config:
  - Stimulus: remote=3 with MAX_LG=2 (RATE_W=2).
  - Required: cfg_err=1, user_marker=0, marker_vld=0; after restoring remote=1, SETTLE then normal run.
- Checker (macro on, CHK_DLY=2):
  - Stimulus: loop user_marker back through a 2-cycle delay.
  - Required: chk_err stays 0.
  - Stimulus: flip bit0 of rx_marker for one cycle.
  - Required: chk_err=1 on the following cycle and held; enable low clears it.
